usb_tx_serializer: RTL and testbench



---
 rtl/usb_pkg.sv | 39 +++
 rtl/usb_crc16_gen.sv | 24 ++
 rtl/usb_tx_serializer.sv | 166 ++++++++++++++++
 tb/tb_usb_tx_serializer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB link definitions: PID codes, SYNC pattern, CRC16 constants,
// the transmit state encoding and a one-bit CRC16 update helper.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  // Sent LSB first: seven zeros then a one.
  localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  localparam int STUFF_RUN = 6;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SYNC,
    TX_PID,
    TX_DATA,
    TX_CRC,
    TX_EOP_SE0,
    TX_EOP_J
  } tx_state_t;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc_in, input logic bit_in);
    logic fb;
    fb = crc_in[15] ^ bit_in;
    crc16_step = {crc_in[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/usb_crc16_gen.sv
// Serial USB CRC16 generator; one bit per enabled cycle, MSB-first LFSR.
// Shared between the transmit serializer and the receive checker.
import usb_pkg::*;

module usb_crc16_gen (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        clear,
  input  logic        enable,
  input  logic        bit_in,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      crc <= CRC16_INIT;
    end else if (clear) begin
      crc <= CRC16_INIT;
    end else if (enable) begin
      crc <= crc16_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/usb_tx_serializer.sv
// USB transmit packet engine: SYNC, PID, optional payload and CRC16, then
// bit stuffing and NRZI onto dp/dm, terminated by SE0 EOP and a J cycle.
import usb_pkg::*;

module usb_tx_serializer #(
  parameter int DATA_BITS      = 64,
  parameter int EOP_SE0_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 start,
  input  logic [3:0]           pid,
  input  logic                 has_data,
  input  logic [DATA_BITS-1:0] data,
  output logic                 busy,
  output logic                 done,
  output logic                 dp,
  output logic                 dm
);

  tx_state_t state_q, state_d, field_next;

  logic [6:0]           bit_cnt_q, bit_cnt_d, field_len;
  logic [2:0]           stuff_cnt_q, stuff_cnt_d, run_next;
  logic                 stuff_q;
  logic                 level_q;
  logic [3:0]           pid_q;
  logic                 has_data_q;
  logic [DATA_BITS-1:0] data_q;
  logic [15:0]          crc;

  logic raw_bit, tx_bit, line_level;
  logic serial, need_stuff, advance, last_bit, accept;

  assign accept = (state_q == TX_IDLE) && start;
  assign serial = (state_q == TX_SYNC) || (state_q == TX_PID) ||
                  (state_q == TX_DATA) || (state_q == TX_CRC);

  // The raw bit of the current field position; a stuff cycle overrides it with 0.
  always_comb begin
    raw_bit    = 1'b1;
    field_len  = 7'd8;
    field_next = TX_EOP_SE0;
    case (state_q)
      TX_SYNC: begin
        raw_bit    = SYNC_PATTERN[bit_cnt_q[2:0]];
        field_next = TX_PID;
      end
      TX_PID: begin
        raw_bit    = pid_q[bit_cnt_q[1:0]] ^ bit_cnt_q[2];
        field_next = has_data_q ? TX_DATA : TX_EOP_SE0;
      end
      TX_DATA: begin
        raw_bit    = data_q[0];
        field_len  = 7'(DATA_BITS);
        field_next = TX_CRC;
      end
      TX_CRC: begin
        raw_bit   = ~crc[4'd15 - bit_cnt_q[3:0]];
        field_len = 7'd16;
      end
      default: ;
    endcase
  end

  assign tx_bit     = raw_bit & ~stuff_q;
  assign line_level = tx_bit ? level_q : ~level_q;
  assign run_next   = tx_bit ? stuff_cnt_q + 3'd1 : 3'd0;
  assign need_stuff = serial && !stuff_q && raw_bit && (stuff_cnt_q == 3'(STUFF_RUN - 1));
  // A bit that completes a run of six holds the field position; the stuff cycle then advances it.
  assign advance    = serial && !need_stuff;
  assign last_bit   = (bit_cnt_q == field_len - 7'd1);
  assign stuff_cnt_d = advance ? run_next : 3'd0;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= TX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    busy      = 1'b1;
    done      = 1'b0;
    dp        = 1'b1;
    dm        = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d   = TX_SYNC;
          bit_cnt_d = 7'd0;
        end
      end
      TX_SYNC, TX_PID, TX_DATA, TX_CRC: begin
        dp = line_level;
        dm = ~line_level;
        if (advance) begin
          if (last_bit) begin
            state_d   = field_next;
            bit_cnt_d = 7'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end
      end
      TX_EOP_SE0: begin
        dp = 1'b0;
        dm = 1'b0;
        if (bit_cnt_q == 7'(EOP_SE0_CYCLES - 1)) begin
          state_d   = TX_EOP_J;
          bit_cnt_d = 7'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + 7'd1;
        end
      end
      TX_EOP_J: begin
        done      = 1'b1;
        state_d   = TX_IDLE;
        bit_cnt_d = 7'd0;
      end
      default: begin
        state_d   = TX_IDLE;
        bit_cnt_d = 7'd0;
      end
    endcase
  end

  // Latched request fields, bit/stuff counters and the NRZI line level.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pid_q       <= 4'd0;
      has_data_q  <= 1'b0;
      data_q      <= '0;
      bit_cnt_q   <= 7'd0;
      stuff_cnt_q <= 3'd0;
      stuff_q     <= 1'b0;
      level_q     <= 1'b1;
    end else begin
      if (accept) begin
        pid_q      <= pid;
        has_data_q <= has_data;
        data_q     <= data;
      end else if ((state_q == TX_DATA) && advance) begin
        data_q <= {1'b0, data_q[DATA_BITS-1:1]};
      end
      bit_cnt_q   <= bit_cnt_d;
      stuff_cnt_q <= stuff_cnt_d;
      stuff_q     <= need_stuff;
      level_q     <= serial ? line_level : 1'b1;
    end
  end

  usb_crc16_gen u_crc (
    .clk    (clk),
    .rst_l  (rst_l),
    .clear  (accept),
    .enable ((state_q == TX_DATA) && !stuff_q),
    .bit_in (data_q[0]),
    .crc    (crc)
  );

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Self-checking bench for usb_tx_serializer: decodes NRZI, unstuffs and checks
// packets from a vector table, plus busy/back-to-back and mid-packet reset cases.
module tb_usb_tx_serializer;

  logic        clk;
  logic        rst_l;
  logic        start;
  logic [3:0]  pid;
  logic        has_data;
  logic [63:0] data;
  logic        busy;
  logic        done;
  logic        dp;
  logic        dm;

  int checks;
  int errors;

  usb_tx_serializer #(.DATA_BITS(64), .EOP_SE0_CYCLES(2)) dut (
    .clk      (clk),
    .rst_l    (rst_l),
    .start    (start),
    .pid      (pid),
    .has_data (has_data),
    .data     (data),
    .busy     (busy),
    .done     (done),
    .dp       (dp),
    .dm       (dm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pid;
    logic        has_data;
    logic [63:0] data;
    logic [15:0] exp_first16;
    int          exp_early_stuffs;
  } vec_t;

  vec_t vecs[6];

  logic [15:0] rx_first16;
  logic [63:0] rx_data;
  logic [15:0] rx_resid;
  int          rx_bits_n;
  int          rx_stuffs_early;
  int          rx_stuff_err;
  int          rx_max_run;
  int          rx_se0;
  int          rx_busy_bad;
  int          rx_timeout;
  logic        rx_j_ok;
  logic        rx_idle_ok;
  logic        rx_bits[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge of the first SYNC cycle.
  task automatic applyStimulus(input logic [3:0] p, input logic hd, input logic [63:0] d);
    @(negedge clk);
    pid      = p;
    has_data = hd;
    data     = d;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [15:0] rxCrc(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
  endfunction

  task automatic receivePacket();
    logic prev_level;
    logic b;
    int   ones;
    int   cyc;
    int   run_len;
    logic [15:0] c;
    prev_level = 1'b1;
    ones = 0;
    cyc = 0;
    run_len = 0;
    rx_bits.delete();
    rx_first16 = '0;
    rx_data = '0;
    rx_stuffs_early = 0;
    rx_stuff_err = 0;
    rx_max_run = 0;
    rx_se0 = 0;
    rx_busy_bad = 0;
    rx_timeout = 0;
    while (!(dp === 1'b0 && dm === 1'b0) && rx_timeout == 0) begin
      if (cyc > 0 && dp == prev_level) run_len++;
      else run_len = 1;
      if (run_len > rx_max_run) rx_max_run = run_len;
      b = (dp == prev_level);
      prev_level = dp;
      if (cyc < 16) rx_first16[cyc] = b;
      if (busy !== 1'b1 || done !== 1'b0) rx_busy_bad++;
      if (ones == 6) begin
        if (b) rx_stuff_err++;
        if (rx_bits.size() <= 80) rx_stuffs_early++;
        ones = 0;
      end else begin
        rx_bits.push_back(b);
        ones = b ? ones + 1 : 0;
      end
      cyc++;
      if (cyc > 200) rx_timeout = 1;
      else @(negedge clk);
    end
    while (rx_timeout == 0 && dp === 1'b0 && dm === 1'b0 && rx_se0 < 10) begin
      if (busy !== 1'b1 || done !== 1'b0) rx_busy_bad++;
      rx_se0++;
      @(negedge clk);
    end
    rx_j_ok = (dp === 1'b1 && dm === 1'b0 && done === 1'b1 && busy === 1'b1);
    @(negedge clk);
    rx_idle_ok = (busy === 1'b0 && done === 1'b0 && dp === 1'b1 && dm === 1'b0);
    rx_bits_n = rx_bits.size();
    c = 16'hFFFF;
    if (rx_bits_n >= 96) begin
      for (int i = 0; i < 64; i++) rx_data[i] = rx_bits[16 + i];
      for (int i = 16; i < 96; i++) c = rxCrc(c, rx_bits[i]);
    end
    rx_resid = c;
  endtask

  task automatic runVector(input vec_t v, input string tag);
    applyStimulus(v.pid, v.has_data, v.data);
    receivePacket();
    checkOutput({tag, " timeout"}, rx_timeout, 0);
    checkOutput({tag, " first16"}, rx_first16, v.exp_first16);
    checkOutput({tag, " unstuffed_len"}, rx_bits_n, v.has_data ? 96 : 16);
    checkOutput({tag, " se0_cycles"}, rx_se0, 2);
    checkOutput({tag, " eop_j_done"}, rx_j_ok, 1);
    checkOutput({tag, " idle_after"}, rx_idle_ok, 1);
    checkOutput({tag, " busy_done_in_pkt"}, rx_busy_bad, 0);
    checkOutput({tag, " stuff_bit_zero"}, rx_stuff_err, 0);
    checkOutput({tag, " max_run_le7"}, rx_max_run <= 7, 1);
    if (v.has_data) begin
      checkOutput({tag, " payload"}, rx_data, v.data);
      checkOutput({tag, " crc_residual"}, rx_resid, 16'h800D);
      checkOutput({tag, " early_stuffs"}, rx_stuffs_early, v.exp_early_stuffs);
    end
  endtask

  initial begin
    int done_cyc;
    int busy_gap;
    int drain;
    logic idle_busy, idle_dp, restart_busy, restart_dp;

    checks   = 0;
    errors   = 0;
    rst_l    = 1'b0;
    start    = 1'b0;
    pid      = 4'd0;
    has_data = 1'b0;
    data     = '0;

    vecs[0] = '{4'b0010, 1'b0, 64'h0, 16'hD280, 0};
    vecs[1] = '{4'b1010, 1'b0, 64'h0, 16'h5A80, 0};
    vecs[2] = '{4'b1110, 1'b0, 64'h0, 16'h1E80, 0};
    vecs[3] = '{4'b0011, 1'b1, 64'h0123_4567_89AB_CDEF, 16'hC380, 1};
    vecs[4] = '{4'b1011, 1'b1, 64'h0, 16'h4B80, 0};
    vecs[5] = '{4'b0011, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 16'hC380, 11};

    repeat (3) @(negedge clk);
    checkOutput("reset dp", dp, 1);
    checkOutput("reset dm", dm, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    rst_l = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      runVector(vecs[i], $sformatf("vec%0d", i));
      @(negedge clk);
    end

    $display("[TB] busy handling with start held high");
    @(negedge clk);
    pid      = 4'b0010;
    has_data = 1'b0;
    start    = 1'b1;
    done_cyc = -1;
    busy_gap = 0;
    idle_busy = 1'b1;
    idle_dp = 1'b0;
    restart_busy = 1'b0;
    restart_dp = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (c <= 19 && busy !== 1'b1) busy_gap++;
      if (c == 20) begin
        idle_busy = busy;
        idle_dp   = dp;
      end
      if (c == 21) begin
        restart_busy = busy;
        restart_dp   = dp;
      end
    end
    start = 1'b0;
    checkOutput("hold done_cycle", done_cyc, 19);
    checkOutput("hold busy_gap", busy_gap, 0);
    checkOutput("hold idle_busy", idle_busy, 0);
    checkOutput("hold idle_dp", idle_dp, 1);
    checkOutput("hold restart_busy", restart_busy, 1);
    checkOutput("hold restart_dp", restart_dp, 0);
    drain = 0;
    while (busy === 1'b1 && drain < 40) begin
      drain++;
      @(negedge clk);
    end
    checkOutput("hold drained", busy, 0);
    @(negedge clk);

    $display("[TB] reset during 30th data bit");
    applyStimulus(4'b1011, 1'b1, 64'h0);
    repeat (45) @(negedge clk);
    checkOutput("midrst busy_before", busy, 1);
    rst_l = 1'b0;
    #1;
    checkOutput("midrst dp", dp, 1);
    checkOutput("midrst dm", dm, 0);
    checkOutput("midrst busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    runVector(vecs[0], "post_reset_ack");
    @(negedge clk);
    runVector(vecs[3], "post_reset_data0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
